// File: rtl/ldpc_frame_sequencer_if.sv
// ============================================================================
//  Module   : AxisIf
//  Purpose  : Minimal AXI-Stream bundle (tdata/tvalid/tready/tlast) shared by
//             the LDPC frame sequencer control, status and data streams.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface AxisIf #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/ldpc_frame_sequencer.sv
// ============================================================================
//  Module   : ldpc_frame_sequencer
//  Purpose  : Accepts one job descriptor, gates exactly N data beats through
//             with a forced tlast on beat N, then emits one status word.
//             Optional watchdog enabled by defining LDPC_SEQ_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ldpc_frame_sequencer #(
    parameter int CTRL_WIDTH     = 32,
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire   clk,
    input  wire   rst,
    AxisIf.slave  s_axis_ctrl,
    AxisIf.slave  s_axis_din,
    AxisIf.master m_axis_dout,
    AxisIf.master m_axis_status
);

    if (CTRL_WIDTH < 32) begin : g_bad_ctrl_width
        $error("ldpc_frame_sequencer: CTRL_WIDTH must be >= 32");
    end
    if ($bits(s_axis_din.tdata) != DATA_WIDTH || $bits(m_axis_dout.tdata) != DATA_WIDTH) begin : g_bad_data_width
        $error("ldpc_frame_sequencer: data stream widths must equal DATA_WIDTH");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("ldpc_frame_sequencer: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STATUS = 2'd2
    } state_t;

    state_t      state_q;
    logic        alive_q;
    logic [15:0] cnt_q;
    logic [15:0] n_q;
    logic [7:0]  id_q;
    logic        zero_len_q;
    logic        tlast_early_q;
    logic        tlast_missing_q;
    logic        timeout_q;

    logic w_in_idle;
    logic w_in_run;
    logic w_in_status;
    logic w_ctrl_hs;
    logic w_din_hs;
    logic w_last_beat;
    logic w_wd_expire;
    logic w_unused_ctrl;

    // alive_q keeps ctrl tready low for as long as rst is held.
    assign w_in_idle   = alive_q && (state_q == S_IDLE);
    assign w_in_run    = (state_q == S_RUN);
    assign w_in_status = (state_q == S_STATUS);
    assign w_ctrl_hs   = w_in_idle && s_axis_ctrl.tvalid;
    assign w_din_hs    = w_in_run && s_axis_din.tvalid && m_axis_dout.tready;
    assign w_last_beat = (cnt_q == (n_q - 16'd1));

    assign s_axis_ctrl.tready  = w_in_idle;
    assign s_axis_din.tready   = w_in_run && m_axis_dout.tready;
    assign m_axis_dout.tvalid  = w_in_run && s_axis_din.tvalid;
    assign m_axis_dout.tdata   = s_axis_din.tdata;
    assign m_axis_dout.tlast   = w_in_run && w_last_beat;

    assign m_axis_status.tvalid = w_in_status;
    assign m_axis_status.tlast  = w_in_status;
    assign m_axis_status.tdata  = CTRL_WIDTH'({timeout_q, tlast_missing_q, tlast_early_q,
                                               zero_len_q, id_q, cnt_q});

    assign w_unused_ctrl = ^{s_axis_ctrl.tdata[CTRL_WIDTH-1:24], s_axis_ctrl.tlast};

`ifdef LDPC_SEQ_TIMEOUT_EN
    localparam int C_WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [C_WD_W-1:0] wd_q;

    // Counts consecutive RUN cycles without a din handshake.
    assign w_wd_expire = w_in_run && !w_din_hs && (wd_q == C_WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else if (!w_in_run || w_din_hs) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end
`else
    assign w_wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            alive_q         <= 1'b0;
            cnt_q           <= '0;
            n_q             <= '0;
            id_q            <= '0;
            zero_len_q      <= 1'b0;
            tlast_early_q   <= 1'b0;
            tlast_missing_q <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (w_ctrl_hs) begin
                        n_q             <= s_axis_ctrl.tdata[15:0];
                        id_q            <= s_axis_ctrl.tdata[23:16];
                        cnt_q           <= '0;
                        tlast_early_q   <= 1'b0;
                        tlast_missing_q <= 1'b0;
                        timeout_q       <= 1'b0;
                        zero_len_q      <= (s_axis_ctrl.tdata[15:0] == 16'd0);
                        state_q         <= (s_axis_ctrl.tdata[15:0] == 16'd0) ? S_STATUS : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_din_hs) begin
                        cnt_q <= cnt_q + 16'd1;
                        if (w_last_beat) begin
                            tlast_missing_q <= !s_axis_din.tlast;
                            state_q         <= S_STATUS;
                        end else if (s_axis_din.tlast) begin
                            tlast_early_q <= 1'b1;
                        end
                    end else if (w_wd_expire) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_STATUS;
                    end
                end
                S_STATUS: begin
                    if (m_axis_status.tready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ldpc_frame_sequencer.sv
// ============================================================================
//  Module   : tb_ldpc_frame_sequencer
//  Purpose  : Randomized self-checking bench for ldpc_frame_sequencer against
//             a job-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ldpc_frame_sequencer;

    localparam int CW = 32;
    localparam int DW = 64;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    AxisIf #(.WIDTH(CW)) ctrl_if ();
    AxisIf #(.WIDTH(DW)) din_if ();
    AxisIf #(.WIDTH(DW)) dout_if ();
    AxisIf #(.WIDTH(CW)) stat_if ();

    ldpc_frame_sequencer #(
        .CTRL_WIDTH     (CW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_ctrl   (ctrl_if),
        .s_axis_din    (din_if),
        .m_axis_dout   (dout_if),
        .m_axis_status (stat_if)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] last_status;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One job: model tracks phase (1=RUN, 2=STATUS), beats, idle run and flags.
    task automatic run_job(input int n, input int id, input logic [31:0] tl_mask,
                           input bit rnd, input int abort_after, input int stall_after);
        int          beats = 0;
        int          idle  = 0;
        int          ph;
        int          budget;
        bit          early = 0, missing = 0, tmo = 0, st_done = 0, d_hs;
        logic [7:0]  junk;
        logic [7:0]  id8;
        logic [15:0] n16;
        logic [31:0] exp_w;

        last_status = 32'hDEADBEEF;
        budget = 8 * n + 200;
        junk = 8'($urandom);
        id8  = 8'(id);
        n16  = 16'(n);

        @(negedge clk);
        ctrl_if.tdata  = {junk, id8, n16};
        ctrl_if.tvalid = 1'b1;
        din_if.tvalid  = 1'b0;
        stat_if.tready = 1'b0;
        #1;
        chk("ctrl_rdy_idle", ctrl_if.tready, 1'b1);
        chk("st_vld_idle", stat_if.tvalid, 1'b0);
        @(posedge clk);
        ph = (n == 0) ? 2 : 1;

        for (int cyc = 0; cyc < budget && !st_done; cyc++) begin
            @(negedge clk);
            ctrl_if.tvalid = rnd ? 1'($urandom) : 1'b0;
            ctrl_if.tdata  = $urandom;
            din_if.tvalid  = (stall_after >= 0 && beats >= stall_after) ? 1'b0
                           : (rnd ? 1'($urandom) : 1'b1);
            din_if.tdata   = {$urandom, $urandom};
            din_if.tlast   = (beats < 32) ? tl_mask[beats] : 1'b0;
            dout_if.tready = rnd ? 1'($urandom) : 1'b1;
            stat_if.tready = rnd ? 1'($urandom) : 1'b1;
            #1;
            chk("ctrl_rdy_busy", ctrl_if.tready, 1'b0);
            if (ph == 1) begin
                chk("dout_vld", dout_if.tvalid, din_if.tvalid);
                chk("din_rdy", din_if.tready, dout_if.tready);
                chk("st_vld_run", stat_if.tvalid, 1'b0);
                d_hs = din_if.tvalid && dout_if.tready;
                if (d_hs) begin
                    chk("dout_data", dout_if.tdata, din_if.tdata);
                    chk("dout_last", dout_if.tlast, (beats == n - 1));
                    if (beats == n - 1) missing = !din_if.tlast;
                    else if (din_if.tlast) early = 1'b1;
                    beats++;
                    idle = 0;
                    if (abort_after > 0 && beats == abort_after) begin
                        @(posedge clk);
                        #2;
                        rst = 1'b1;
                        din_if.tvalid  = 1'b1;
                        ctrl_if.tvalid = 1'b0;
                        #1;
                        chk("rst_dout_vld", dout_if.tvalid, 1'b0);
                        chk("rst_st_vld", stat_if.tvalid, 1'b0);
                        chk("rst_din_rdy", din_if.tready, 1'b0);
                        chk("rst_ctrl_rdy", ctrl_if.tready, 1'b0);
                        @(negedge clk);
                        rst = 1'b0;
                        din_if.tvalid = 1'b0;
                        repeat (3) begin
                            @(negedge clk);
                            #1;
                            chk("post_rst_st_vld", stat_if.tvalid, 1'b0);
                            chk("post_rst_ctrl_rdy", ctrl_if.tready, 1'b1);
                        end
                        return;
                    end
                    if (beats == n) ph = 2;
                end else begin
                    idle++;
`ifdef LDPC_SEQ_TIMEOUT_EN
                    if (idle == TO) begin
                        tmo = 1'b1;
                        ph  = 2;
                    end
`endif
                end
            end else begin
                chk("din_rdy_st", din_if.tready, 1'b0);
                chk("dout_vld_st", dout_if.tvalid, 1'b0);
                exp_w = {4'b0, tmo, missing, early, (n == 0), id8, 16'(beats)};
                chk("st_vld", stat_if.tvalid, 1'b1);
                chk("st_last", stat_if.tlast, 1'b1);
                chk("st_data", stat_if.tdata, exp_w);
                if (stat_if.tready) begin
                    last_status = stat_if.tdata;
                    st_done = 1'b1;
                end
            end
            @(posedge clk);
        end
        chk("job_budget", st_done, 1'b1);
    endtask

    initial begin
        int          rn;
        logic [31:0] rmask;

        ctrl_if.tvalid = 1'b0;
        ctrl_if.tdata  = '0;
        ctrl_if.tlast  = 1'b0;
        din_if.tvalid  = 1'b0;
        din_if.tdata   = '0;
        din_if.tlast   = 1'b0;
        dout_if.tready = 1'b1;
        stat_if.tready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        din_if.tvalid = 1'b1;
        #1;
        chk("reset_ctrl_rdy", ctrl_if.tready, 1'b0);
        chk("reset_din_rdy", din_if.tready, 1'b0);
        chk("reset_dout_vld", dout_if.tvalid, 1'b0);
        chk("reset_st_vld", stat_if.tvalid, 1'b0);
        rst = 1'b0;
        din_if.tvalid = 1'b0;

        run_job(4, 8'h5A, 32'b1000, 1'b0, 0, -1);
        chk("tp1_status", last_status, 32'h005A0004);
        run_job(3, 8'h22, 32'b010, 1'b0, 0, -1);
        chk("tp2_status", last_status, 32'h06220003);
        run_job(0, 8'h11, 32'h0, 1'b0, 0, -1);
        chk("tp3_status", last_status, 32'h01110000);

        run_job(1, int'($urandom_range(0, 255)), 32'h1, 1'b1, 0, -1);
        run_job(7, int'($urandom_range(0, 255)), 32'h40, 1'b1, 0, -1);
        run_job(2, int'($urandom_range(0, 255)), 32'h2, 1'b1, 0, -1);

        run_job(5, 8'h33, 32'h10, 1'b1, 2, -1);
        run_job(5, 8'h34, 32'h10, 1'b0, 0, -1);
        chk("tp5_status", last_status, 32'h00340005);

        for (int j = 0; j < 8; j++) begin
            rn    = int'($urandom_range(0, 20));
            rmask = $urandom & $urandom;
            if (rn > 0 && ($urandom_range(0, 3) != 0)) rmask[rn-1] = 1'b1;
            run_job(rn, int'($urandom_range(0, 255)), rmask, 1'b1, 0, -1);
        end

`ifdef LDPC_SEQ_TIMEOUT_EN
        run_job(4, 8'h44, 32'h8, 1'b0, 0, 2);
        chk("tp6_status", last_status, 32'h08440002);
`endif

        run_job(65535, 8'hFF, 32'h0, 1'b0, 0, -1);
        chk("max_n_status", last_status, 32'h04FFFFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ldpc_frame_sequencer.md
# ldpc_frame_sequencer

Frame-level controller placed in front of the LDPC decoder loop. It accepts one job descriptor on the control stream and gates exactly the described number of data beats from the input stream to the output stream, forcing `tlast` on the final beat. It then emits one status word per job carrying job ID, beat count and error flags. This serialises jobs so control and data can never drift out of alignment.

## Interface
- `CTRL_WIDTH`, default 32: width of the control and status streams; must be ≥ 32.
- `DATA_WIDTH`, default 128: width of the data streams; `s_axis_din` and `m_axis_dout` must match (elaboration `$error` otherwise).
- `TIMEOUT_CYCLES`, default 1024: watchdog limit; used only when the configuration macro is defined.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`, input, 1: sole clock; all streams are synchronous to it.
- `rst`, input, 1: asynchronous, active-high reset.
- `s_axis_ctrl`, `AxisIf.slave`, `CTRL_WIDTH`: job descriptors.
  - `[15:0]` beat count N.
  - `[23:16]` job ID.
  - Other bits are ignored.
- `s_axis_din`, `AxisIf.slave`, `DATA_WIDTH`: frame payload in.
- `m_axis_dout`, `AxisIf.master`, `DATA_WIDTH`: frame payload out, toward the decoder loop.
- `m_axis_status`, `AxisIf.master`, `CTRL_WIDTH`: one status word per job.
  - `[15:0]` beats transferred.
  - `[23:16]` job ID.
  - `[24]` zero_len.
  - `[25]` tlast_early.
  - `[26]` tlast_missing.
  - `[27]` timeout.
  - Upper bits are 0.

## Operation
- The FSM has three states: IDLE, RUN, STATUS.
- IDLE:
  - `s_axis_ctrl.tready`=1; all other readies and valids are 0.
  - On a ctrl handshake: latch N and ID, clear the flags, clear the beat counter.
  - If N≠0, go to RUN.
  - If N=0, set zero_len and go to STATUS.
- RUN (the data path is a combinational pass-through):
  - `m_axis_dout.tvalid`=`s_axis_din.tvalid`.
  - `s_axis_din.tready`=`m_axis_dout.tready`.
  - `tdata` is passed unchanged.
  - `m_axis_dout.tlast`=1 only on beat N (when counter = N−1). The input `tlast` is never forwarded.
  - Each handshake increments the 16-bit counter.
- Input `tlast` checking in RUN:
  - `tlast` asserted on beat k<N sets tlast_early. The beat is still forwarded and the frame continues to N.
  - `tlast` low on beat N sets tlast_missing.
- When the handshake of beat N completes, go to STATUS.
- STATUS:
  - `m_axis_status.tvalid`=1, `tlast`=1, `tdata` = assembled word.
  - Data readies and valids are 0; `s_axis_ctrl.tready`=0.
  - On the status handshake, go to IDLE.
- Only one job is in flight at a time; ctrl is back-pressured from RUN through STATUS.
- `tkeep`/`tuser`, if present on the interface: passed through on data, driven to 0/all-ones-keep on status.

## Timing
- Reset values:
  - State = IDLE; counter, N, ID and flags = 0.
  - `m_axis_dout.tvalid`=0, `m_axis_status.tvalid`=0, `s_axis_din.tready`=0, `s_axis_ctrl.tready`=0 while `rst` is high; 1 from the first cycle after deassertion.
- Ctrl accept at cycle t puts the block in RUN at t+1; the first data beat can transfer at t+1.
- Data latency is 0 cycles (combinational).
- The beat-N handshake at cycle t gives status `tvalid` at t+1 and is held until `tready`. `tdata` is stable while `tvalid`=1.
- After the status handshake at t, IDLE (ctrl tready=1) at t+1. Minimum job period is N+2 cycles.
- N=0: ctrl accept at t gives status at t+1 with beats=0, zero_len=1.
- N=65535: the counter must not wrap before completion.
- Reset mid-job: immediate return to IDLE. The partial frame is dropped without `tlast` and no status is emitted.

## Configuration
- `LDPC_SEQ_TIMEOUT_EN` defined:
  - In RUN, a watchdog counts consecutive cycles without a din handshake and resets on each handshake.
  - On reaching `TIMEOUT_CYCLES`, set timeout and go to STATUS with beats = the count transferred so far. `m_axis_dout` receives no forced `tlast`.
- Not defined: no watchdog logic. RUN waits indefinitely and bit 27 is always 0.

## Test plan
- Ctrl N=4, ID=0x5A; 4 din beats with `tlast` on beat 4 → 4 dout beats, `tlast` only on the 4th; status = 0x005A0004.
- Ctrl N=3, din `tlast` on beat 2 and beat 3 low → 3 dout beats, `tlast` on the 3rd; status bits 25 and 26 = 1, beats = 3.
- Ctrl N=0, ID=0x11 → no dout beats; status = 0x01110000 one cycle after ctrl accept.
- Random `tvalid`/`tready` toggling on din, dout and status over 3 back-to-back jobs (N=1, 7, 2) → data order preserved, 3 status words in order, ctrl tready low outside IDLE.
- `rst` pulsed after beat 2 of N=5 → all valids drop immediately, no status; a new job then completes normally.
- With `LDPC_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: N=4, stop din after 2 beats → status after 16 idle cycles with bit 27=1, beats=2.
